// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing control for the 5-stage core: latch enables, bubbles/flushes,
// load-use stalls, taken-branch squash and the multi-cycle mul/div handshake.
module pipe_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [31:0]      fd_ir,
  input  logic [31:0]      dx_ir,
  input  logic             br_taken,
  input  logic             md_ready,
  input  logic             md_error,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_abort,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TMR_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MD_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [TMR_W-1:0] tmr_reg, tmr_next;
  logic             abort_reg, abort_next;
  logic [CNT_W-1:0] cnt_reg;

  // Instruction field decode
  logic [4:0] dx_op, dx_rd, dx_aluop;
  logic [4:0] fd_op, fd_rs, fd_rt;
  logic       dx_is_lw, dx_is_md, fd_uses_rt, load_use;

  assign dx_op    = dx_ir[31:27];
  assign dx_rd    = dx_ir[26:22];
  assign dx_aluop = dx_ir[6:2];
  assign fd_op    = fd_ir[31:27];
  assign fd_rs    = fd_ir[21:17];
  assign fd_rt    = fd_ir[16:12];

  assign dx_is_lw   = (dx_op == 5'b01000);
  assign dx_is_md   = (dx_op == 5'b00000) && ((dx_aluop == 5'b00110) || (dx_aluop == 5'b00111));
  // Only R-type and sw read the rt field as a source; elsewhere it is a destination or immediate.
  assign fd_uses_rt = (fd_op == 5'b00000) || (fd_op == 5'b00111);
  assign load_use   = dx_is_lw && (dx_rd != 5'd0) &&
                      ((fd_rs == dx_rd) || (fd_uses_rt && (fd_rt == dx_rd)));

  // md_error is consumed by the datapath exception logic; unused fields are folded here.
  logic unused_bits;
  assign unused_bits = ^{md_error, fd_ir[26:22], fd_ir[11:0], dx_ir[21:7], dx_ir[1:0]};

  always_ff @(posedge clk) begin
    if (!clear) begin
      state_reg <= ST_IDLE;
      tmr_reg   <= '0;
      abort_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      tmr_reg   <= tmr_next;
      abort_reg <= abort_next;
      if (!pc_en && (cnt_reg != {CNT_W{1'b1}}))
        cnt_reg <= cnt_reg + 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    tmr_next   = tmr_reg;
    abort_next = abort_reg;
    case (state_reg)
      ST_IDLE: begin
        if (dx_is_md && !br_taken) begin
          state_next = ST_BUSY;
          tmr_next   = '0;
        end
      end
      ST_BUSY: begin
        if (md_ready) begin
          state_next = ST_DONE;
        end else if (tmr_reg == TMR_LAST) begin
          abort_next = 1'b1;
          state_next = ST_DONE;
        end else begin
          tmr_next = tmr_reg + 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_en     = 1'b1;
    fd_en     = 1'b1;
    dx_en     = 1'b1;
    fd_flush  = 1'b0;
    dx_bubble = 1'b0;
    xm_bubble = 1'b0;
    md_start  = 1'b0;
    md_busy   = 1'b0;
    // While reset is held the pipeline sees plain no-hazard controls.
    if (clear) begin
      case (state_reg)
        ST_IDLE: begin
          if (br_taken) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end else if (dx_is_md) begin
            md_start  = 1'b1;
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_en     = 1'b0;
            xm_bubble = 1'b1;
          end else if (load_use) begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            dx_bubble = 1'b1;
          end
        end
        ST_BUSY: begin
          pc_en     = 1'b0;
          fd_en     = 1'b0;
          dx_en     = 1'b0;
          xm_bubble = 1'b1;
          md_busy   = 1'b1;
        end
        ST_DONE: begin
          if (br_taken) begin
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign md_abort    = abort_reg;
  assign stall_count = cnt_reg;

endmodule
